// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the serial 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned N_TAPS = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: acc_out = acc_in + a*b, truncated to ACC_W.
module mac_unit #(
  parameter int unsigned DATA_W = conv_pkg::DATA_W,
  parameter int unsigned ACC_W  = conv_pkg::ACC_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;

  // Full-width product so nothing is lost before the accumulator wraps.
  assign prod    = PROD_W'(a) * PROD_W'(b);
  assign acc_out = acc_in + ACC_W'(prod);

endmodule

// File: rtl/conv2d_serial.sv
// Serial 3x3 convolution: captures window and kernel on start, then one MAC per
// clock for nine cycles, and publishes the sum with a one-cycle done strobe.
module conv2d_serial #(
  parameter int unsigned DATA_W = conv_pkg::DATA_W,
  parameter int unsigned ACC_W  = conv_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic [DATA_W-1:0] k0,
  input  logic [DATA_W-1:0] k1,
  input  logic [DATA_W-1:0] k2,
  input  logic [DATA_W-1:0] k3,
  input  logic [DATA_W-1:0] k4,
  input  logic [DATA_W-1:0] k5,
  input  logic [DATA_W-1:0] k6,
  input  logic [DATA_W-1:0] k7,
  input  logic [DATA_W-1:0] k8,
  output logic [ACC_W-1:0]  out,
  output logic              done
);

  import conv_pkg::*;

  logic [DATA_W-1:0] px [N_TAPS];
  logic [DATA_W-1:0] kw [N_TAPS];

  assign px = '{in0, in1, in2, in3, in4, in5, in6, in7, in8};
  assign kw = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] px_q [N_TAPS];
  logic [DATA_W-1:0] px_d [N_TAPS];
  logic [DATA_W-1:0] kw_q [N_TAPS];
  logic [DATA_W-1:0] kw_d [N_TAPS];

  logic [DATA_W-1:0] a_sel_c;
  logic [DATA_W-1:0] b_sel_c;
  logic [ACC_W-1:0]  mac_sum_c;

  // 9:1 operand mux steered by the tap index.
  assign a_sel_c = px_q[idx_q];
  assign b_sel_c = kw_q[idx_q];

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a       (a_sel_c),
    .b       (b_sel_c),
    .acc_in  (acc_q),
    .acc_out (mac_sum_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(N_TAPS); i++) begin
        px_q[i] <= '0;
        kw_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
      px_q    <= px_d;
      kw_q    <= kw_d;
    end
  end

  // DONE accepts a new start just like IDLE, giving a 10-cycle back-to-back rate.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    px_d    = px_q;
    kw_d    = kw_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          px_d    = px;
          kw_d    = kw;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = mac_sum_c;
        if (idx_q == IDX_W'(N_TAPS - 1)) begin
          out_d   = mac_sum_c;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_conv2d_serial.sv
// Directed bench for conv2d_serial: vector table plus hand-written corner sequences.
module tb_conv2d_serial;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int NV = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_v [9];
  logic [DW-1:0] k_v  [9];
  logic [AW-1:0] out;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [8:0][7:0] px;
    logic [8:0][7:0] kw;
    logic [15:0]     exp_out;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  conv2d_serial #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in0 (in_v[0]), .in1 (in_v[1]), .in2 (in_v[2]),
    .in3 (in_v[3]), .in4 (in_v[4]), .in5 (in_v[5]),
    .in6 (in_v[6]), .in7 (in_v[7]), .in8 (in_v[8]),
    .k0  (k_v[0]),  .k1  (k_v[1]),  .k2  (k_v[2]),
    .k3  (k_v[3]),  .k4  (k_v[4]),  .k5  (k_v[5]),
    .k6  (k_v[6]),  .k7  (k_v[7]),  .k8  (k_v[8]),
    .out   (out),
    .done  (done)
  );

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic drive_ops(input vec_t v);
    for (int i = 0; i < 9; i++) begin
      in_v[i] = v.px[i];
      k_v[i]  = v.kw[i];
    end
  endtask

  // Called just after a falling edge; returns just after the capture edge.
  task automatic launch(input vec_t v);
    drive_ops(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Number of falling-edge samples until done is seen, -1 if the budget expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    vec_t zero_v;

    zero_v = '0;
    for (int v = 0; v < NV; v++) vecs[v] = '0;
    for (int i = 0; i < 9; i++) begin
      vecs[0].px[i] = 8'd1;             vecs[0].kw[i] = 8'd1;
      vecs[1].px[i] = 8'(i + 1);        vecs[1].kw[i] = 8'(9 - i);
      vecs[2].px[i] = 8'd255;           vecs[2].kw[i] = 8'd255;
      vecs[3].px[i] = 8'(i);            vecs[3].kw[i] = 8'd2;
      vecs[4].px[i] = 8'd7;             vecs[4].kw[i] = 8'd0;
    end
    vecs[4].px[4] = 8'd10;
    vecs[4].kw[4] = 8'd20;
    vecs[0].exp_out = 16'd9;
    vecs[1].exp_out = 16'd165;
    vecs[2].exp_out = 16'd60937;
    vecs[3].exp_out = 16'd72;
    vecs[4].exp_out = 16'd200;

    drive_ops(zero_v);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      launch(vecs[v]);
      check($sformatf("v%0d_done_early", v), int'(done), 0);
      wait_done(n);
      check($sformatf("v%0d_latency", v), n, 9);
      check($sformatf("v%0d_out", v), int'(out), int'(vecs[v].exp_out));
      drive_ops(zero_v);
      @(negedge clk);
      check($sformatf("v%0d_done_width", v), int'(done), 0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_out_held", v), int'(out), int'(vecs[v].exp_out));
    end

    // Second start mid-RUN with zeroed operands must be ignored.
    launch(vecs[1]);
    repeat (3) @(negedge clk);
    drive_ops(zero_v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("midrun_latency", n, 5);
    check("midrun_out", int'(out), 165);
    count_done(15, cnt);
    check("midrun_single_done", cnt, 0);

    // Reset partway through RUN aborts the computation and clears out.
    launch(vecs[2]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out", int'(out), 0);
    check("midreset_done", int'(done), 0);
    rst = 1'b1;
    count_done(15, cnt);
    check("midreset_no_done", cnt, 0);
    launch(vecs[1]);
    wait_done(n);
    check("postreset_latency", n, 9);
    check("postreset_out", int'(out), 165);
    @(negedge clk);

    // Back-to-back: restart during the done cycle.
    launch(vecs[0]);
    wait_done(n);
    check("b2b_first_latency", n, 9);
    check("b2b_first_out", int'(out), 9);
    drive_ops(vecs[3]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_low", int'(done), 0);
    check("b2b_out_holds", int'(out), 9);
    wait_done(n);
    check("b2b_second_latency", n, 9);
    check("b2b_second_out", int'(out), 72);
    @(negedge clk);

    // Reset wins over a simultaneous start.
    drive_ops(vecs[2]);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    check("rst_vs_start_out", int'(out), 0);
    count_done(12, cnt);
    check("rst_vs_start_no_done", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
